// File: rtl/mac_accum_engine_pkg.sv
// Shared types and sizing helpers for the MAC accumulate engine.
// Mode index m (0..2) selects 8b/4b/2b slices throughout the design.
package mac_accum_engine_pkg;

    typedef enum logic [1:0] {
        MODE_2B  = 2'b00,
        MODE_4B  = 2'b01,
        MODE_8B  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    localparam int NUM_MODES = 3;
    localparam int MAX_LANES = 16;

    // m=0 -> 8-bit slices, m=1 -> 4-bit, m=2 -> 2-bit
    function automatic int slice_bits(input int m);
        return 8 >> m;
    endfunction

    function automatic int lane_cnt(input int m);
        return (8 / slice_bits(m)) * (8 / slice_bits(m));
    endfunction

    function automatic int lane_w(input int m, input int guard);
        return 2 * slice_bits(m) + guard;
    endfunction

    function automatic mode_e mode_of_idx(input int m);
        case (m)
            0:       return MODE_8B;
            1:       return MODE_4B;
            default: return MODE_2B;
        endcase
    endfunction

    // The reserved encoding runs as full 8-bit precision.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSV) ? MODE_8B : mode_e'(m);
    endfunction

endpackage

// File: rtl/mac_accum_engine_if.sv
// Host-side control, beat input and result output of the MAC accumulate engine.
// master drives batches and beats; slave is the engine.
interface mac_accum_engine_if #(
    parameter int GUARD_BITS = 4,
    parameter int CNT_W      = 8
);
    localparam int OUT_W = 16 * (4 + GUARD_BITS);

    logic             clr;
    logic             start;
    logic [CNT_W-1:0] batch_len;
    logic [1:0]       mode;
    logic             sx;
    logic             sy;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       act;
    logic [7:0]       wgt;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             busy;

    modport master (
        output clr, start, batch_len, mode, sx, sy, in_valid, act, wgt, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  clr, start, batch_len, mode, sx, sy, in_valid, act, wgt, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );

endinterface

// File: rtl/mac_accum_engine_lane_acc.sv
// One accumulator lane: extends a 2P-bit slice product to LW bits, adds it,
// and flags wrap-around (signed overflow or unsigned carry-out).
module mac_lane_acc #(
    parameter int P = 2,
    parameter int G = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             en,
    input  logic             sgn,
    input  logic [2*P-1:0]   prod,
    output logic [2*P+G-1:0] acc,
    output logic             ovf
);
    localparam int LW = 2 * P + G;

    logic [LW-1:0] acc_q, acc_d;
    logic [LW-1:0] ext;
    logic [LW:0]   sum;

    always_comb begin
        ext = sgn ? {{G{prod[2*P-1]}}, prod} : {{G{1'b0}}, prod};
        sum = {1'b0, acc_q} + {1'b0, ext};
        if (sgn)
            ovf = (acc_q[LW-1] == ext[LW-1]) && (sum[LW-1] != acc_q[LW-1]);
        else
            ovf = sum[LW];

        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sum[LW-1:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_accum_engine.sv
// Batch MAC engine: per-mode lane banks accumulate slice products over N beats,
// then the packed lane sums are held on a valid/ready result port.
module mac_accum_engine
    import mac_accum_engine_pkg::*;
#(
    parameter int GUARD_BITS = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                nrst,
    mac_accum_engine_if.slave   bus
);
    localparam int OUT_W = 16 * (4 + GUARD_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] len_q, len_d;
    mode_e            mode_q, mode_d;
    logic             sx_q, sx_d;
    logic             sy_q, sy_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic             acc_clr;
    logic             ovf_hit;
    logic [OUT_W-1:0] out_mux;
    logic [OUT_W-1:0] mode_pk [NUM_MODES];
    logic             mode_ovf [NUM_MODES];

    assign beat = bus.in_valid && (state_q == ST_ACCUM);

    // One bank of lanes per precision; only the latched mode's bank advances.
    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        localparam int P  = slice_bits(m);
        localparam int S  = 8 / P;
        localparam int NL = lane_cnt(m);
        localparam int LW = lane_w(m, GUARD_BITS);

        logic [NL-1:0][LW-1:0] acc;
        logic [NL-1:0]         lane_ovf;
        logic                  lane_en;

        assign lane_en = beat && (mode_q == mode_of_idx(m));

        for (genvar i = 0; i < S; i++) begin : g_act
            for (genvar j = 0; j < S; j++) begin : g_wgt
                logic signed [2*P-1:0] a_e, w_e, prod;

                assign a_e  = {{P{sx_q & bus.act[i*P+P-1]}}, bus.act[i*P +: P]};
                assign w_e  = {{P{sy_q & bus.wgt[j*P+P-1]}}, bus.wgt[j*P +: P]};
                assign prod = a_e * w_e;

                mac_lane_acc #(.P(P), .G(GUARD_BITS)) u_lane (
                    .clk  (clk),
                    .nrst (nrst),
                    .clr  (acc_clr),
                    .en   (lane_en),
                    .sgn  (sx_q | sy_q),
                    .prod (prod),
                    .acc  (acc[i*S+j]),
                    .ovf  (lane_ovf[i*S+j])
                );
            end
        end

        assign mode_pk[m]  = OUT_W'(acc);
        assign mode_ovf[m] = |lane_ovf;
    end

    always_comb begin
        out_mux = '0;
        ovf_hit = 1'b0;
        for (int m = 0; m < NUM_MODES; m++) begin
            if (mode_q == mode_of_idx(m)) begin
                out_mux = mode_pk[m];
                ovf_hit = mode_ovf[m];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        len_d   = len_q;
        mode_d  = mode_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ovf_d   = ovf_q;
        acc_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_clr = 1'b1;
                    state_d = (bus.batch_len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    ctr_d = ctr_q + CNT_ONE;
                    ovf_d = ovf_q | ovf_hit;
                    if (ctr_q == len_q - CNT_ONE)
                        state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    // Back-to-back batch: the handshake cycle doubles as a start cycle.
                    if (bus.start) begin
                        acc_clr = 1'b1;
                        state_d = (bus.batch_len == '0) ? ST_HOLD : ST_ACCUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (acc_clr) begin
            ctr_d  = '0;
            ovf_d  = 1'b0;
            len_d  = bus.batch_len;
            mode_d = norm_mode(bus.mode);
            sx_d   = bus.sx;
            sy_d   = bus.sy;
        end

        if (bus.clr) begin
            state_d = ST_IDLE;
            ctr_d   = '0;
            ovf_d   = 1'b0;
            acc_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_8B;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_data  = out_mux;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum_engine.sv
// Directed + randomized bench for mac_accum_engine; expected sums come from an
// integer-arithmetic lane model over the queued beats.
module tb_mac_accum_engine;
    logic clk = 1'b0;
    logic nrst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]   aq[$];
    logic [7:0]   wq[$];
    logic [127:0] exp_d;
    logic         exp_o;

    mac_accum_engine_if #(.GUARD_BITS(4), .CNT_W(8)) bus ();

    mac_accum_engine #(.GUARD_BITS(4), .CNT_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // md: 0=2b, 1=4b, else 8b. Lane sums kept as plain integers modulo 2**LW.
    function automatic void model(input int md, input bit sxv, input bit syv,
                                  output logic [127:0] d, output logic o);
        int p, s, lw, a, w, k;
        longint m, v, sa;
        longint acc[16];
        p  = (md == 0) ? 2 : (md == 1) ? 4 : 8;
        s  = 8 / p;
        lw = 2 * p + 4;
        m  = longint'(1) << lw;
        foreach (acc[i]) acc[i] = 0;
        o = 1'b0;
        for (int b = 0; b < aq.size(); b++)
            for (int i = 0; i < s; i++)
                for (int j = 0; j < s; j++) begin
                    a = (int'(aq[b]) >> (i * p)) & ((1 << p) - 1);
                    w = (int'(wq[b]) >> (j * p)) & ((1 << p) - 1);
                    if (sxv && a >= (1 << (p - 1))) a -= (1 << p);
                    if (syv && w >= (1 << (p - 1))) w -= (1 << p);
                    k = i * s + j;
                    if (sxv || syv) begin
                        sa = (acc[k] >= m / 2) ? acc[k] - m : acc[k];
                        v  = sa + longint'(a * w);
                        if (v < -(m / 2) || v >= m / 2) o = 1'b1;
                    end else begin
                        v = acc[k] + longint'(a * w);
                        if (v >= m) o = 1'b1;
                    end
                    acc[k] = ((v % m) + m) % m;
                end
        d = '0;
        for (int kk = 0; kk < s * s; kk++)
            for (int bt = 0; bt < lw; bt++)
                d[kk * lw + bt] = acc[kk][bt];
    endfunction

    task automatic fill_const(input int n, input logic [7:0] a, input logic [7:0] w);
        aq.delete(); wq.delete();
        for (int i = 0; i < n; i++) begin aq.push_back(a); wq.push_back(w); end
    endtask

    task automatic fill_rand(input int n);
        aq.delete(); wq.delete();
        for (int i = 0; i < n; i++) begin
            aq.push_back(8'($urandom)); wq.push_back(8'($urandom));
        end
    endtask

    task automatic start_batch(input int md, input bit sxv, input bit syv, input int n);
        bus.start     = 1'b1;
        bus.mode      = 2'(md);
        bus.sx        = sxv;
        bus.sy        = syv;
        bus.batch_len = 8'(n);
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic feed(input bit stall, input int nb);
        int idx = 0;
        int cyc = 0;
        bit iv;
        while (idx < nb && cyc < 1000) begin
            iv = stall ? (cyc % 2 == 0) : 1'b1;
            bus.in_valid = iv;
            bus.act      = aq[idx];
            bus.wgt      = wq[idx];
            if (iv && bus.in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("feed_beats_taken", 128'(idx), 128'(nb));
    endtask

    task automatic expect_result(input string tag, input int md, input bit sxv, input bit syv);
        model(md, sxv, syv, exp_d, exp_o);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_data"},  bus.out_data,  exp_d);
        chk({tag, "_ovf"},   bus.out_ovf,   exp_o);
    endtask

    task automatic handshake();
        chk("hold_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_hs_valid", bus.out_valid, 1'b0);
        chk("post_hs_busy",  bus.busy,      1'b0);
        chk("idle_in_ready", bus.in_ready,  1'b0);
    endtask

    initial begin
        int md, n;
        bit sxv, syv, st;
        logic [127:0] keep_d;
        logic         keep_o;

        nrst = 1'b0;
        bus.clr = 1'b0; bus.start = 1'b0; bus.batch_len = '0; bus.mode = '0;
        bus.sx = 1'b0; bus.sy = 1'b0; bus.in_valid = 1'b0; bus.act = '0; bus.wgt = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_data",  bus.out_data,  '0);
        chk("rst_ovf",   bus.out_ovf,   1'b0);
        chk("rst_ready", bus.in_ready,  1'b0);
        chk("rst_busy",  bus.busy,      1'b0);
        nrst = 1'b1;
        @(negedge clk);

        // 8b signed: -3 * 5 three times
        fill_const(3, 8'hFD, 8'h05);
        start_batch(2, 1, 1, 3);
        chk("t1_in_ready", bus.in_ready, 1'b1);
        feed(0, 3);
        expect_result("t1", 2, 1, 1);
        chk("t1_literal", bus.out_data, 128'h0FFFD3);
        handshake();

        // 4b unsigned, lanes 6,8,12,16; valid directly after the last beat
        fill_const(2, 8'h21, 8'h43);
        start_batch(1, 0, 0, 2);
        feed(0, 2);
        expect_result("t2", 1, 0, 0);
        chk("t2_literal", bus.out_data, {80'h0, 12'd16, 12'd12, 12'd8, 12'd6});
        handshake();

        // 2b unsigned wrap: 29 * 9 = 261 -> 5 per lane
        fill_const(29, 8'hFF, 8'hFF);
        start_batch(0, 0, 0, 29);
        feed(0, 29);
        expect_result("t3", 0, 0, 0);
        chk("t3_literal", bus.out_data, {16{8'h05}});
        chk("t3_ovf_lit", bus.out_ovf, 1'b1);
        handshake();

        // result held under backpressure, then back-to-back start
        fill_rand(6);
        start_batch(1, 1, 0, 6);
        feed(0, 6);
        model(1, 1, 0, keep_d, keep_o);
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", bus.out_valid, 1'b1);
            chk("t4_hold_data",  bus.out_data,  keep_d);
            chk("t4_hold_ovf",   bus.out_ovf,   keep_o);
            @(negedge clk);
        end
        fill_rand(4);
        bus.out_ready = 1'b1;
        start_batch(2, 0, 1, 4);
        bus.out_ready = 1'b0;
        chk("t4_b2b_valid", bus.out_valid, 1'b0);
        chk("t4_b2b_ready", bus.in_ready,  1'b1);
        feed(0, 4);
        expect_result("t4b", 2, 0, 1);
        handshake();

        // alternating in_valid gives the same sums
        fill_rand(4);
        start_batch(0, 1, 1, 4);
        feed(1, 4);
        expect_result("t5", 0, 1, 1);
        handshake();

        // zero-length batch goes straight to an all-zero result
        start_batch(1, 0, 0, 0);
        chk("t0_valid", bus.out_valid, 1'b1);
        chk("t0_data",  bus.out_data,  '0);
        handshake();

        // randomized batches, reserved mode included
        for (int r = 0; r < 8; r++) begin
            md  = $urandom_range(0, 3);
            sxv = 1'($urandom);
            syv = 1'($urandom);
            st  = 1'($urandom);
            n   = $urandom_range(1, 24);
            fill_rand(n);
            start_batch(md, sxv, syv, n);
            feed(st, n);
            expect_result("rnd", md, sxv, syv);
            handshake();
        end

        // async reset mid-batch
        fill_rand(5);
        start_batch(2, 0, 0, 5);
        feed(0, 2);
        #2 nrst = 1'b0;
        #1;
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_busy",  bus.busy,      1'b0);
        chk("t6_rst_ready", bus.in_ready,  1'b0);
        chk("t6_rst_data",  bus.out_data,  '0);
        chk("t6_rst_ovf",   bus.out_ovf,   1'b0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // synchronous clr mid-batch, then a clean batch
        fill_const(5, 8'hFF, 8'hFF);
        start_batch(0, 0, 0, 5);
        feed(0, 2);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("t6_clr_busy", bus.busy,     1'b0);
        chk("t6_clr_data", bus.out_data, '0);
        chk("t6_clr_ovf",  bus.out_ovf,  1'b0);
        fill_rand(3);
        start_batch(1, 1, 1, 3);
        feed(0, 3);
        expect_result("t6_clean", 1, 1, 1);
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
